// File: rtl/pll_rst_seq.sv
// pll_rst_seq: power-up and relock sequencer for the 100 MHz PLL.
// Debounces lock, stages domain reset release, retries, latches fault.
module pll_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_DOMAINS   = 3,
    parameter int STAGE_GAP     = 64,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk_100m,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   sys_ready,
    output logic                   fault,
    output logic [CNT_W-1:0]       lock_loss_cnt
);

    localparam int MAX_A = (RST_CYCLES > STAGE_GAP) ? RST_CYCLES : STAGE_GAP;
    localparam int MAX_B = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                           LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_C) + 1;
    localparam int RW    = $clog2(MAX_RETRY + 1);

    localparam logic [NUM_DOMAINS-1:0] DOM_LSB = NUM_DOMAINS'(1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [RW-1:0]          retry_inc;
    logic [2:0]             sync_q, sync_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic                   lk;

    assign lk = sync_q[2];

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        retry_d     = retry_q;
        pll_reset_d = pll_reset_q;
        dom_d       = dom_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        loss_d      = loss_q;
        sync_d      = {sync_q[1:0], pll_locked};
        retry_inc   = retry_q + RW'(1);

        unique case (state_q)
            S_PLL_RST: begin
                if (tmr_q == TW'(RST_CYCLES - 1)) begin
                    state_d     = S_WAIT_LOCK;
                    tmr_d       = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d     = retry_inc;
                    tmr_d       = '0;
                    pll_reset_d = 1'b1;
                    if (retry_inc == RW'(MAX_RETRY)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_PLL_RST;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    tmr_d = '0;
                end else if (tmr_q == TW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    tmr_d   = '0;
                    retry_d = '0;
                    dom_d   = DOM_LSB;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RELEASE: begin
                if (!lk) begin
                    state_d     = S_PLL_RST;
                    tmr_d       = '0;
                    pll_reset_d = 1'b1;
                    dom_d       = '0;
                end else if (dom_q[NUM_DOMAINS-1]) begin
                    state_d = S_RUN;
                    tmr_d   = '0;
                    ready_d = 1'b1;
                end else if (tmr_q == TW'(STAGE_GAP - 1)) begin
                    // shifting in ones keeps the release order monotonic
                    dom_d = (dom_q << 1) | DOM_LSB;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d     = S_PLL_RST;
                    tmr_d       = '0;
                    retry_d     = '0;
                    pll_reset_d = 1'b1;
                    dom_d       = '0;
                    ready_d     = 1'b0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + CNT_W'(1);
                    end
                end
            end
            S_FAULT: begin
                pll_reset_d = 1'b1;
                dom_d       = '0;
                ready_d     = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = S_PLL_RST;
                tmr_d       = '0;
                pll_reset_d = 1'b1;
                dom_d       = '0;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            tmr_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            dom_q       <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pll_reset_q <= pll_reset_d;
            dom_q       <= dom_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            loss_q      <= loss_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign dom_rst_n     = dom_q;
    assign sys_ready     = ready_q;
    assign fault         = fault_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed bench for pll_rst_seq with a time-based
// reference model checked every cycle plus hand-computed milestones.
module tb_pll_rst_seq;

    localparam int RST_C = 4;
    localparam int TMO   = 20;
    localparam int STB   = 8;
    localparam int ND    = 3;
    localparam int GAP   = 5;
    localparam int MAXR  = 2;
    localparam int CW    = 2;
    localparam int LOSS_MAX = 3;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_REL  = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_FLT  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          pll_reset;
    logic [ND-1:0] dom_rst_n;
    logic          sys_ready;
    logic          fault;
    logic [CW-1:0] lock_loss_cnt;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STB),
        .NUM_DOMAINS  (ND),
        .STAGE_GAP    (GAP),
        .MAX_RETRY    (MAXR),
        .CNT_W        (CW)
    ) dut (
        .clk_100m     (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_reset    (pll_reset),
        .dom_rst_n    (dom_rst_n),
        .sys_ready    (sys_ready),
        .fault        (fault),
        .lock_loss_cnt(lock_loss_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: phase plus cycles elapsed in that phase.
    int     m_ph, m_t, m_retry, m_loss;
    bit     m_lk, m_ok;
    bit [2:0] m_hist;

    function automatic int ones(input int n);
        return (1 << n) - 1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ph = PH_RST; m_t = 0; m_retry = 0; m_loss = 0;
            m_hist = '0; m_ok = 1'b1;
        end else if (m_ok) begin
            m_lk   = m_hist[2];
            m_hist = {m_hist[1:0], pll_locked};
            case (m_ph)
                PH_RST: begin
                    if (m_t + 1 == RST_C) begin
                        m_ph = PH_WAIT; m_t = 0;
                    end else m_t++;
                end
                PH_WAIT: begin
                    if (m_lk) begin
                        m_ph = PH_STAB; m_t = 0;
                    end else if (m_t + 1 == TMO) begin
                        m_retry++; m_t = 0;
                        m_ph = (m_retry == MAXR) ? PH_FLT : PH_RST;
                    end else m_t++;
                end
                PH_STAB: begin
                    m_t = m_lk ? m_t + 1 : 0;
                    if (m_t == STB) begin
                        m_ph = PH_REL; m_t = 0; m_retry = 0;
                    end
                end
                PH_REL: begin
                    if (!m_lk) begin
                        m_ph = PH_RST; m_t = 0;
                    end else if (m_t == (ND - 1) * GAP) begin
                        m_ph = PH_RUN; m_t = 0;
                    end else m_t++;
                end
                PH_RUN: begin
                    if (!m_lk) begin
                        m_ph = PH_RST; m_t = 0; m_retry = 0;
                        if (m_loss < LOSS_MAX) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        int e_dom;
        if (m_ok) begin
            e_dom = 0;
            if (m_ph == PH_REL) begin
                e_dom = ones((1 + m_t / GAP > ND) ? ND : 1 + m_t / GAP);
            end else if (m_ph == PH_RUN) begin
                e_dom = ones(ND);
            end
            check("m_pll_reset", pll_reset,
                  (m_ph == PH_RST || m_ph == PH_FLT) ? 1 : 0);
            check("m_dom_rst_n", dom_rst_n, e_dom);
            check("m_sys_ready", sys_ready, (m_ph == PH_RUN) ? 1 : 0);
            check("m_fault", fault, (m_ph == PH_FLT) ? 1 : 0);
            check("m_lock_loss", lock_loss_cnt, m_loss);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_low();
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_dom_rst_n"}, dom_rst_n, 0);
        check({tag, "_sys_ready"}, sys_ready, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_lock_loss"}, lock_loss_cnt, 0);
    endtask

    task automatic wait_ready(input string tag, input bit lvl);
        for (int i = 0; i < 80 && sys_ready != lvl; i++) @(negedge clk);
        check(tag, sys_ready, lvl);
    endtask

    initial begin
        int n, base, falls, tf;
        int t1, t3, t7, tr;
        bit prev;

        // power-up with lock arriving at cycle 10
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("t1_rst");
        rst = 1'b0;
        n = 0;
        while (pll_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t1_prst_len", n, 4);
        wait_cyc(9);
        pll_locked = 1'b1;
        t1 = -1; t3 = -1; t7 = -1; tr = -1;
        for (int i = 0; i < 60 && tr < 0; i++) begin
            @(negedge clk);
            if (dom_rst_n == 3'b001 && t1 < 0) t1 = cyc;
            if (dom_rst_n == 3'b011 && t3 < 0) t3 = cyc;
            if (dom_rst_n == 3'b111 && t7 < 0) t7 = cyc;
            if (sys_ready && tr < 0) tr = cyc;
        end
        check("t1_dom001_at", t1, 21);
        check("t1_dom011_at", t3, 26);
        check("t1_dom111_at", t7, 31);
        check("t1_ready_at", tr, 32);

        // one-cycle lock loss in RUN
        wait_cyc(40);
        pulse_low();
        tf = -1;
        for (int i = 0; i < 20 && tf < 0; i++) begin
            if (!sys_ready) tf = cyc;
            else @(negedge clk);
        end
        check("t3_drop_at", tf, 44);
        check("t3_dom_zero", dom_rst_n, 0);
        check("t3_loss_cnt", lock_loss_cnt, 1);
        tr = -1;
        for (int i = 0; i < 60 && tr < 0; i++) begin
            @(negedge clk);
            if (sys_ready) tr = cyc;
        end
        check("t3_ready_again_at", tr, 68);

        // lock glitch in STABLE at count 6
        rst = 1'b1;
        pll_locked = 1'b1;
        @(negedge clk);
        check_reset("t4_rst");
        rst = 1'b0;
        base = cyc;
        wait_cyc(base + 8);
        pulse_low();
        t1 = -1; tr = -1;
        for (int i = 0; i < 60 && tr < 0; i++) begin
            @(negedge clk);
            if (dom_rst_n == 3'b001 && t1 < 0) t1 = cyc;
            if (sys_ready && tr < 0) tr = cyc;
        end
        check("t4_dom001_at", t1 - base, 20);
        check("t4_ready_at", tr - base, 31);

        // repeated lock losses saturate the 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            repeat (2) @(negedge clk);
            pulse_low();
            wait_ready("t6_drop_seen", 1'b0);
            check("t6_loss_cnt", lock_loss_cnt, (k > LOSS_MAX) ? LOSS_MAX : k);
            wait_ready("t6_ready_seen", 1'b1);
        end

        // rst while in RELEASE with dom_rst_n=011
        pulse_low();
        for (int i = 0; i < 80 && dom_rst_n != 3'b011; i++) @(negedge clk);
        check("t5_in_release", dom_rst_n, 3);
        rst = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        check_reset("t5_rel_rst");
        rst = 1'b0;
        base = cyc;

        // no lock: two timeouts then FAULT
        falls = 0;
        tf = -1;
        prev = pll_reset;
        for (int i = 0; i < 100 && tf < 0; i++) begin
            @(negedge clk);
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
            if (fault && tf < 0) tf = cyc;
        end
        check("t2_fault_at", tf - base, 48);
        check("t2_prst_falls", falls, 2);
        check("t2_prst_high", pll_reset, 1);
        pll_locked = 1'b1;
        repeat (40) @(negedge clk);
        check("t2_fault_sticky", fault, 1);
        check("t2_prst_sticky", pll_reset, 1);
        check("t2_dom_low", dom_rst_n, 0);

        // rst while in FAULT
        rst = 1'b1;
        @(negedge clk);
        check_reset("t5_flt_rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
